// File: rtl/fixed_point_mul_seq.sv
// fixed_point_mul_seq: sequential Q10.6 signed multiplier (sign-magnitude shift-add, 16 steps)
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operands a/b presented
//   in_ready   out  1   high in IDLE, operands accepted on in_valid && in_ready
//   a, b       in   16  signed Q10.6 operands
//   out_valid  out  1   high in DONE, result/overflow valid
//   out_ready  in   1   consumer takes result
//   result     out  16  signed Q10.6 product (magnitude truncated toward zero)
//   overflow   out  1   product outside Q10.6 range
//
// Build option: define FXP_MUL_SAT_EN to saturate result on overflow;
// otherwise the low 16 bits of the signed product are returned (wrap).
module fixed_point_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic        sign;
    logic [31:0] mcand;
    logic [15:0] mplier;
    logic [31:0] acc;
    logic [3:0]  cnt;
    logic        accept;
    logic        last;
    logic [31:0] acc_nxt;
    logic [31:0] m;
    logic [15:0] wrap;
    logic [15:0] res_nxt;
    logic        ovf_nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: if (cnt == 4'd15) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign last    = (state == BUSY) && (cnt == 4'd15);
    // Multiplier is consumed LSB first while the multiplicand shifts left.
    assign acc_nxt = acc + (mplier[0] ? mcand : 32'd0);
    assign m       = acc_nxt >> 6;
    assign ovf_nxt = sign ? (m > 32'd32768) : (m > 32'd32767);
    // Negating m == 0 yields 0, so no negative zero can appear.
    assign wrap    = sign ? (16'd0 - m[15:0]) : m[15:0];
`ifdef FXP_MUL_SAT_EN
    assign res_nxt = ovf_nxt ? (sign ? 16'h8000 : 16'h7fff) : wrap;
`else
    assign res_nxt = wrap;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sign     <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            sign   <= a[15] ^ b[15];
            // Two's complement of 16'h8000 is 16'h8000, i.e. 32768 unsigned.
            mcand  <= {16'd0, a[15] ? 16'd0 - a : a};
            mplier <= b[15] ? 16'd0 - b : b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 4'd1;
            if (last) begin
                result   <= res_nxt;
                overflow <= ovf_nxt;
            end
        end
endmodule

// File: tb/tb_fixed_point_mul_seq.sv
// tb_fixed_point_mul_seq: directed self-checking bench for fixed_point_mul_seq
module tb_fixed_point_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic        overflow;
    int          checks = 0;
    int          fails = 0;

    fixed_point_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Drives one transaction; lat counts cycles from accept to out_valid (bounded at 40).
    // Operands are scrambled after acceptance to show they are not re-sampled.
    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input bit take,
                          output logic [15:0] r, output logic o, output int lat);
        @(negedge clk);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            a = ~a;
            b = b + 16'd1;
            lat++;
        end while (!out_valid && lat < 40);
        r = result;
        o = overflow;
        if (take) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (result !== 16'h0000) begin fails++; $display("FAIL reset_result got %h want 0000", result); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] va [7] = '{16'd64, 16'hFFC0, 16'hFFC0, 16'd32, 16'hFFFF, 16'h8000, 16'd0};
        logic [15:0] vb [7] = '{16'd128, 16'd128, 16'hFF80, 16'd32, 16'd1, 16'd64, 16'd0};
        logic [15:0] er [7] = '{16'd128, 16'hFF80, 16'd128, 16'd16, 16'd0, 16'h8000, 16'd0};
        logic [15:0] r;
        logic        o;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], 1'b1, r, o, lat);
            checks++; if (r !== er[i]) begin fails++; $display("FAIL basic_result[%0d] got %h want %h", i, r, er[i]); end
            checks++; if (o !== 1'b0) begin fails++; $display("FAIL basic_overflow[%0d] got %b want 0", i, o); end
            checks++; if (lat !== 17) begin fails++; $display("FAIL basic_latency[%0d] got %0d want 17", i, lat); end
            checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready_after[%0d] got %b want 1", i, in_ready); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] va [3] = '{16'd6465, 16'hE6BF, 16'h8000};
        logic [15:0] vb [3] = '{16'd482, 16'd482, 16'hFFC0};
`ifdef FXP_MUL_SAT_EN
        logic [15:0] er [3] = '{16'h7FFF, 16'h8000, 16'h7FFF};
`else
        logic [15:0] er [3] = '{16'hBE31, 16'h41CF, 16'h8000};
`endif
        logic [15:0] r;
        logic        o;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b1, r, o, lat);
            checks++; if (r !== er[i]) begin fails++; $display("FAIL ovf_result[%0d] got %h want %h", i, r, er[i]); end
            checks++; if (o !== 1'b1) begin fails++; $display("FAIL ovf_flag[%0d] got %b want 1", i, o); end
            checks++; if (lat !== 17) begin fails++; $display("FAIL ovf_latency[%0d] got %0d want 17", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] r;
        logic        o;
        int          lat;
        bit          seen;
        run_op(16'd64, 16'd128, 1'b0, r, o, lat);
        checks++; if (r !== 16'd128) begin fails++; $display("FAIL bp_result got %h want 0080", r); end
        checks++; if (lat !== 17) begin fails++; $display("FAIL bp_latency got %0d want 17", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = 16'h1234;
            b = 16'h0100;
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (result !== 16'd128) begin fails++; $display("FAIL bp_hold_result[%0d] got %h want 0080", i, result); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL bp_ignored_ops got out_valid=%b want 0", seen); end
        run_op(16'd32, 16'd32, 1'b1, r, o, lat);
        checks++; if (r !== 16'd16) begin fails++; $display("FAIL bp_next_result got %h want 0010", r); end
    endtask

    task automatic test_mid_reset();
        logic [15:0] r;
        logic        o;
        int          lat;
        bit          seen;
        @(negedge clk);
        a = 16'd64;
        b = 16'd128;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mr_busy_in_ready got %b want 0", in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mr_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mr_out_valid got %b want 0", out_valid); end
        checks++; if (result !== 16'h0000) begin fails++; $display("FAIL mr_result got %h want 0000", result); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL mr_overflow got %b want 0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL mr_no_out_valid got %b want 0", seen); end
        run_op(16'd64, 16'd128, 1'b1, r, o, lat);
        checks++; if (r !== 16'd128) begin fails++; $display("FAIL mr_next_result got %h want 0080", r); end
        checks++; if (lat !== 17) begin fails++; $display("FAIL mr_next_latency got %0d want 17", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
